// File: rtl/btn_pkg.sv
// Shared constants for the front-panel button event path: press FSM states,
// event kind encoding and the default button count.
package btn_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  localparam logic EV_SHORT = 1'b0;
  localparam logic EV_LONG  = 1'b1;

  localparam int unsigned N_BTN_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a saturating debounce counter; db rises
// DEB_LIMIT+1 cycles after the synced level goes high and drops one cycle after it goes low.
module btn_debounce #(
  parameter int unsigned DEB_LIMIT = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int unsigned CW = $clog2(DEB_LIMIT + 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_db;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      if (!r_s2) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else begin
        if (r_cnt != CW'(DEB_LIMIT))
          r_cnt <= r_cnt + 1'b1;
        r_db <= (r_cnt >= CW'(DEB_LIMIT));
      end
    end
  end

  assign db = r_db;

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces each button, classifies every press as short or long, and hands
// one pending event at a time to the consumer via round-robin valid/ready.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN      = N_BTN_DEFAULT,
  parameter int unsigned DEB_LIMIT  = 2500,
  parameter int unsigned LONG_LIMIT = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     ev_valid,
  output logic [$clog2(N_BTN)-1:0] ev_btn,
  output logic                     ev_long,
  input  logic                     ev_ready,
  output logic                     ev_drop
);

  localparam int unsigned BW = $clog2(N_BTN);
  localparam int unsigned HW = $clog2(LONG_LIMIT + 1);

  logic [N_BTN-1:0] w_db;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
      btn_debounce #(.DEB_LIMIT(DEB_LIMIT)) u_deb (
        .clk (clk),
        .rst (rst),
        .raw (btn_in[gi]),
        .db  (w_db[gi])
      );
    end
  endgenerate

  logic [1:0]    r_state [N_BTN];
  logic [HW-1:0] r_hold  [N_BTN];
  logic [N_BTN-1:0] w_post;
  logic [N_BTN-1:0] w_post_kind;

  // In IDLE db can only be high on its rising edge, since both exits to IDLE require db low.
  always_comb begin
    w_post      = '0;
    w_post_kind = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (r_state[i] == S_PRESS) begin
        if (!w_db[i]) begin
          w_post[i]      = 1'b1;
          w_post_kind[i] = EV_SHORT;
        end else if (r_hold[i] == HW'(LONG_LIMIT - 1)) begin
          w_post[i]      = 1'b1;
          w_post_kind[i] = EV_LONG;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        r_state[i] <= S_IDLE;
        r_hold[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_db[i]) begin
              r_state[i] <= S_PRESS;
              r_hold[i]  <= '0;
            end
          end
          S_PRESS: begin
            if (!w_db[i])
              r_state[i] <= S_IDLE;
            else if (r_hold[i] == HW'(LONG_LIMIT - 1))
              r_state[i] <= S_HELD;
            else
              r_hold[i] <= r_hold[i] + 1'b1;
          end
          S_HELD: begin
            if (!w_db[i])
              r_state[i] <= S_IDLE;
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_kind;
  logic [BW-1:0]    r_ptr;
  logic             r_ev_valid;
  logic [BW-1:0]    r_ev_btn;
  logic             r_ev_long;
  logic             r_ev_drop;

  logic             w_free;
  logic             w_found;
  logic [BW-1:0]    w_sel;
  logic [BW-1:0]    w_ptr_next;
  logic [N_BTN-1:0] w_grant;
  logic             w_drop;

  assign w_free = !r_ev_valid || ev_ready;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      int unsigned j;
      j = 32'(r_ptr) + k;
      if (j >= N_BTN)
        j = j - N_BTN;
      if (!w_found && r_pend[j]) begin
        w_found = 1'b1;
        w_sel   = BW'(j);
      end
    end
    w_grant = '0;
    if (w_free && w_found)
      w_grant[w_sel] = 1'b1;
  end

  assign w_ptr_next = (w_sel == BW'(N_BTN - 1)) ? '0 : w_sel + 1'b1;
  assign w_drop     = |(w_post & r_pend & ~w_grant);

  // A post coinciding with a grant of the same button re-arms pend with the new kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_kind <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (w_post[i]) begin
          if (!r_pend[i] || w_grant[i]) begin
            r_pend[i] <= 1'b1;
            r_kind[i] <= w_post_kind[i];
          end
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_ev_valid <= 1'b0;
      r_ev_btn   <= '0;
      r_ev_long  <= 1'b0;
      r_ev_drop  <= 1'b0;
    end else begin
      r_ev_drop <= w_drop;
      if (w_free) begin
        if (w_found) begin
          r_ev_valid <= 1'b1;
          r_ev_btn   <= w_sel;
          r_ev_long  <= r_kind[w_sel];
          r_ptr      <= w_ptr_next;
        end else begin
          r_ev_valid <= 1'b0;
        end
      end
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_btn   = r_ev_btn;
  assign ev_long  = r_ev_long;
  assign ev_drop  = r_ev_drop;

endmodule
